pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline stall/flush controller for the five-stage core. It merges stall requests from decode (load-use hazards) and execute (multi-cycle ALU ops such as divide and multiply-accumulate) into a per-stage stall vector. It sequences the iterative multi-cycle unit through a start/ready handshake, with a bounded wait and annul on flush. It also keeps a saturating stall-cycle counter for performance monitoring.

## Interface
- `MC_TIMEOUT`, default 64: maximum cycles spent in WAIT before the operation is abandoned (legal range 2..255).
- `CNT_W`, default 32: width of the stall-cycle counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous reset, active-low (0 = reset).
- `stallreq_id_i`  in  1  decode hazard; stall PC/IF/ID this cycle.
- `mc_req_i`  in  1  instruction in EX needs the multi-cycle unit; held until EX advances.
- `mc_ready_i`  in  1  multi-cycle unit result valid; single-cycle pulse.
- `flush_i`  in  1  exception/redirect; flush the pipeline this cycle.
- `cnt_clr_i`  in  1  synchronous clear of the stall counter.
- `stall_o`  out  6  bit 0 = PC, 1 = IF, 2 = ID, 3 = EX, 4 = MEM, 5 = WB; 1 = hold that stage.
- `flush_o`  out  1  flush IF/ID/EX pipeline registers.
- `mc_start_o`  out  1  one-cycle start pulse to the multi-cycle unit.
- `mc_annul_o`  out  1  one-cycle abort pulse to the multi-cycle unit.
- `mc_done_o`  out  1  EX may capture the unit result this cycle.
- `mc_timeout_o`  out  1  sticky flag: an operation exceeded `MC_TIMEOUT`.
- `stall_cnt_o`  out  `CNT_W`  stall-cycle count.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - `mc_req_i`=1 and `flush_i`=0 → ISSUE.
- ISSUE (exactly one cycle):
  - `mc_start_o`=1; the wait counter is cleared.
  - Next state is WAIT.
- WAIT:
  - `mc_ready_i`=1 → DONE.
  - Otherwise the wait counter increments.
  - When the counter reaches `MC_TIMEOUT`-1 without ready: `mc_annul_o`=1, `mc_timeout_o` is set, next state is DONE. EX receives `mc_done_o` and discards the result.
- DONE (one cycle):
  - `mc_done_o`=1 and the EX stall is released, so the instruction advances at the end of this cycle.
  - `mc_req_i` is ignored this cycle.
  - Next state is IDLE.
- Stall vector, combinational, in priority order:
  - `flush_i`=1 → 6'b000000, `flush_o`=1.
  - EX busy, i.e. state ISSUE or WAIT, or state IDLE with `mc_req_i`=1 → 6'b001111.
  - `stallreq_id_i`=1 → 6'b000111.
  - Otherwise 6'b000000.
- Flush in any state:
  - State → IDLE next cycle.
  - If the current state is ISSUE or WAIT, `mc_annul_o` pulses in that same cycle.
  - A flush in DONE needs no annul.
  - Flush in IDLE with `mc_req_i`=1 does not issue.
- Stall counter:
  - Increments each cycle `stall_o[0]`=1.
  - Saturates at all-ones.
  - `cnt_clr_i` takes priority over increment.
- `mc_timeout_o` clears only on reset.

## Timing
- Reset (`rst`=0), asynchronous: state IDLE, wait counter 0, `stall_cnt_o`=0, `mc_timeout_o`=0.
- During reset, `stall_o`=0, `flush_o`=0, `mc_start_o`=0, `mc_annul_o`=0, `mc_done_o`=0; all are gated combinationally.
- Reset mid-operation abandons it silently, with no annul pulse.
- `stall_o` and `flush_o` are combinational from the inputs and state, with zero-cycle latency.
- `mc_start_o`, `mc_annul_o` and `mc_done_o` are decoded from state, with the flush qualification described under Operation.
- Multi-cycle sequence, with the request seen in cycle 0:
  - Cycle 0: stall asserted.
  - Cycle 1: start.
  - Ready in cycle k ≥ 2 → DONE in k+1; stall released in k+1.
  - Total EX occupancy is k+2 cycles.
- `mc_ready_i` is ignored outside WAIT.
- Ready in the same cycle as the timeout: ready wins, and no annul or timeout flag is raised.

## Structure
- The shared defines header holds:
  - Stall bit indices.
  - Stall vector constants: `StallNone`, `StallId` = 6'b000111, `StallEx` = 6'b001111.
  - State encodings.
- One sub-module, `sat_counter`: parameterised width, with `inc`, `clr` and saturation. It is used for `stall_cnt_o`.

## Test plan
- `stallreq_id_i`=1 for 1 cycle, no `mc_req_i` → `stall_o`=000111 that cycle only; `stall_cnt_o` increments by 1.
- `mc_req_i` held, `mc_ready_i` pulsed 5 cycles after start → `mc_start_o` at cycle 1, `stall_o`=001111 for cycles 0..6, `mc_done_o` at cycle 7 with `stall_o`=0.
- Flush during WAIT → `mc_annul_o`=1 and `flush_o`=1 in the same cycle, `stall_o`=0, IDLE next cycle; a late `mc_ready_i` is ignored.
- `MC_TIMEOUT`=4, no ready → annul in the 4th WAIT cycle, `mc_timeout_o`=1 sticky, `mc_done_o` next cycle; a second op behaves normally and the flag stays set.
- `stallreq_id_i` and `mc_req_i` together → 001111; `stall_cnt_o` forced to all-ones stays saturated; `cnt_clr_i` together with a stall → 0.
- `rst` low during WAIT → all outputs 0 immediately, no annul; after release, IDLE.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller: stall bit
// positions, stall vector constants, FSM state encoding.
package pipe_ctrl_pkg;

  // Stall vector bit positions, one per pipeline stage.
  localparam int unsigned STALL_PC  = 0;
  localparam int unsigned STALL_IF  = 1;
  localparam int unsigned STALL_ID  = 2;
  localparam int unsigned STALL_EX  = 3;
  localparam int unsigned STALL_MEM = 4;
  localparam int unsigned STALL_WB  = 5;
  localparam int unsigned STALL_W   = 6;

  // Stall vector constants: a decode hazard holds PC/IF/ID; a busy EX also holds EX.
  localparam logic [STALL_W-1:0] StallNone = 6'b000000;
  localparam logic [STALL_W-1:0] StallId   = 6'b000111;
  localparam logic [STALL_W-1:0] StallEx   = 6'b001111;

  // Wait counter width; large enough for the largest legal timeout (255).
  localparam int unsigned WAIT_W = 8;

  // Multi-cycle sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } mc_state_e;

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic at_max;

  assign at_max = &count;

  // Count register: clear first, then increment unless already all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !at_max) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller. Merges decode and execute stall requests
// into a per-stage stall vector, sequences the iterative multi-cycle unit
// (start / wait for ready / bounded timeout / annul on flush) and counts
// stalled cycles.
//
// Handshake with the multi-cycle unit: mc_start_o is a one-cycle pulse in
// ISSUE; the unit answers with a one-cycle mc_ready_i pulse, honoured only in
// WAIT; mc_annul_o is a one-cycle pulse that aborts an operation in flight
// (flush in ISSUE/WAIT, or timeout); mc_done_o marks the single cycle in
// which EX captures the result (or discards it after an annul).
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MC_TIMEOUT = 64,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_id_i,
  input  logic             mc_req_i,
  input  logic             mc_ready_i,
  input  logic             flush_i,
  input  logic             cnt_clr_i,
  output logic [5:0]       stall_o,
  output logic             flush_o,
  output logic             mc_start_o,
  output logic             mc_annul_o,
  output logic             mc_done_o,
  output logic             mc_timeout_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  // Current sequencer state; kept as a named signal so checkers can bind to it.
  mc_state_e         state;
  mc_state_e         state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_cnt_next;
  logic              timeout_q;
  logic              timeout_set;
  logic              at_limit;
  logic              expire;
  logic              ex_busy;

  assign at_limit = (wait_cnt == WAIT_W'(MC_TIMEOUT - 1));
  // Operation runs out of time this cycle; a simultaneous ready wins.
  assign expire   = (state == ST_WAIT) && !mc_ready_i && at_limit;
  assign ex_busy  = (state == ST_ISSUE) || (state == ST_WAIT) ||
                    ((state == ST_IDLE) && mc_req_i);

  // State, wait counter and sticky timeout flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      if (timeout_set) begin
        timeout_q <= 1'b1;
      end
    end
  end

  // Next-state, wait counter and timeout-flag decisions; flush overrides everything.
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    timeout_set   = 1'b0;
    if (flush_i) begin
      state_next    = ST_IDLE;
      wait_cnt_next = '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (mc_req_i) begin
            state_next = ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          wait_cnt_next = '0;
          state_next    = ST_WAIT;
        end
        ST_WAIT: begin
          if (mc_ready_i) begin
            state_next = ST_DONE;
          end else if (at_limit) begin
            timeout_set = 1'b1;
            state_next  = ST_DONE;
          end else begin
            wait_cnt_next = wait_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          state_next = ST_IDLE;
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  // Combinational outputs, all forced low while reset is asserted.
  always_comb begin
    stall_o    = StallNone;
    flush_o    = 1'b0;
    mc_start_o = 1'b0;
    mc_annul_o = 1'b0;
    mc_done_o  = 1'b0;
    if (rst) begin
      if (flush_i) begin
        flush_o = 1'b1;
        stall_o = StallNone;
      end else if (ex_busy) begin
        stall_o = StallEx;
      end else if (stallreq_id_i) begin
        stall_o = StallId;
      end
      mc_start_o = (state == ST_ISSUE);
      mc_done_o  = (state == ST_DONE);
      mc_annul_o = (flush_i && ((state == ST_ISSUE) || (state == ST_WAIT))) ||
                   (!flush_i && expire);
    end
  end

  assign mc_timeout_o = timeout_q;

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (stall_o[STALL_PC]),
    .clr  (cnt_clr_i),
    .count(stall_cnt_o)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: two instances (long timeout with a narrow counter,
// short timeout with a wide counter) share one stimulus stream and are
// compared every cycle against an operation-level reference model.
module tb_pipe_ctrl;

  localparam int unsigned LIM_A = 64;
  localparam int unsigned CW_A  = 4;
  localparam int unsigned LIM_B = 4;
  localparam int unsigned CW_B  = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic stallreq_id, mc_req, mc_ready, flush, cnt_clr;

  logic [5:0]      a_stall, b_stall;
  logic            a_flush, a_start, a_annul, a_done, a_to;
  logic            b_flush, b_start, b_annul, b_done, b_to;
  logic [CW_A-1:0] a_cnt;
  logic [CW_B-1:0] b_cnt;

  pipe_ctrl #(.MC_TIMEOUT(LIM_A), .CNT_W(CW_A)) dut_a (
    .clk(clk), .rst(rst), .stallreq_id_i(stallreq_id), .mc_req_i(mc_req),
    .mc_ready_i(mc_ready), .flush_i(flush), .cnt_clr_i(cnt_clr),
    .stall_o(a_stall), .flush_o(a_flush), .mc_start_o(a_start),
    .mc_annul_o(a_annul), .mc_done_o(a_done), .mc_timeout_o(a_to),
    .stall_cnt_o(a_cnt)
  );

  pipe_ctrl #(.MC_TIMEOUT(LIM_B), .CNT_W(CW_B)) dut_b (
    .clk(clk), .rst(rst), .stallreq_id_i(stallreq_id), .mc_req_i(mc_req),
    .mc_ready_i(mc_ready), .flush_i(flush), .cnt_clr_i(cnt_clr),
    .stall_o(b_stall), .flush_o(b_flush), .mc_start_o(b_start),
    .mc_annul_o(b_annul), .mc_done_o(b_done), .mc_timeout_o(b_to),
    .stall_cnt_o(b_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- reference model ----------------
  // Per instance: is an operation outstanding, how many cycles since its
  // start cycle, is this the result-hand-over cycle, sticky timeout, count.
  bit          m_active [2];
  int          m_age    [2];
  bit          m_fin    [2];
  bit          m_to     [2];
  longint      m_cnt    [2];
  int          m_lim    [2] = '{LIM_A, LIM_B};
  longint      m_max    [2] = '{64'd15, 64'hFFFF_FFFF};

  // Expected outputs bundled as {stall[5:0], flush, start, annul, done, timeout}.
  logic [10:0] exp_q[$];

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_active[i] = 0; m_age[i] = 0; m_fin[i] = 0; m_to[i] = 0; m_cnt[i] = 0;
    end
  endfunction

  // Ran out of time: the (lim)-th waiting cycle passes without ready.
  function automatic bit times_out(int i);
    return m_active[i] && (m_age[i] == m_lim[i]) && !mc_ready;
  endfunction

  function automatic logic [5:0] exp_stall(int i);
    if (!rst || flush) return 6'b000000;
    if (m_active[i] || (!m_fin[i] && mc_req)) return 6'b001111;
    if (stallreq_id) return 6'b000111;
    return 6'b000000;
  endfunction

  function automatic logic [10:0] predict(int i);
    logic st, an, dn, fl;
    if (!rst) return {6'b0, 4'b0, 1'b0};
    fl = flush;
    st = m_active[i] && (m_age[i] == 0);
    dn = m_fin[i];
    an = m_active[i] && (flush || times_out(i));
    return {exp_stall(i), fl, st, an, dn, m_to[i]};
  endfunction

  function automatic void model_step(int i);
    bit stall_pc;
    stall_pc = exp_stall(i)[0];
    if (cnt_clr) m_cnt[i] = 0;
    else if (stall_pc && m_cnt[i] < m_max[i]) m_cnt[i]++;
    if (flush) begin
      m_active[i] = 0; m_fin[i] = 0;
    end else if (m_fin[i]) begin
      m_fin[i] = 0;
    end else if (m_active[i]) begin
      if (m_age[i] >= 1 && (mc_ready || times_out(i))) begin
        if (!mc_ready) m_to[i] = 1;
        m_active[i] = 0; m_fin[i] = 1;
      end else begin
        m_age[i]++;
      end
    end else if (mc_req) begin
      m_active[i] = 1; m_age[i] = 0;
    end
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [10:0] e;
    for (int i = 0; i < 2; i++) exp_q.push_back(predict(i));
    e = exp_q.pop_front();
    chk("a_outputs", {21'd0, a_stall, a_flush, a_start, a_annul, a_done, a_to}, {21'd0, e});
    e = exp_q.pop_front();
    chk("b_outputs", {21'd0, b_stall, b_flush, b_start, b_annul, b_done, b_to}, {21'd0, e});
    chk("a_stall_cnt", {28'd0, a_cnt}, m_cnt[0][31:0]);
    chk("b_stall_cnt", b_cnt, m_cnt[1][31:0]);
  endtask

  // ---------------- driver tasks ----------------
  // One clock cycle: drive at the falling edge, check 1 ns later, advance model.
  task automatic cyc(input bit id, input bit req, input bit rdy, input bit fl, input bit clr);
    @(negedge clk);
    stallreq_id = id; mc_req = req; mc_ready = rdy; flush = fl; cnt_clr = clr;
    #1;
    check_outputs();
    @(posedge clk);
    if (rst) begin
      model_step(0);
      model_step(1);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0);
  endtask

  // Asynchronous reset pulse in the middle of a cycle, checked while asserted.
  task automatic pulse_reset(input bit req_during);
    @(negedge clk);
    mc_req = req_during; stallreq_id = req_during; flush = 0; mc_ready = 0; cnt_clr = 0;
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_outputs();
    chk("reset_no_annul_a", {31'd0, a_annul}, 32'd0);
    chk("reset_stall_b", {26'd0, b_stall}, 32'd0);
    @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    mc_req = 0; stallreq_id = 0;
    rst = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit req_h;
    rst = 1'b0;
    stallreq_id = 0; mc_req = 0; mc_ready = 0; flush = 0; cnt_clr = 0;
    model_reset();
    #3;
    check_outputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    idle(2);

    // Decode hazard for a single cycle.
    cyc(1, 0, 0, 0, 0);
    idle(2);

    // Multi-cycle op, ready pulsed five cycles after start (instance B times out meanwhile).
    cyc(0, 1, 0, 0, 0);
    for (int k = 1; k <= 5; k++) cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 1, 0, 0);
    cyc(0, 1, 0, 0, 0);
    idle(8);

    // Flush during WAIT, then a late ready.
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 1, 0);
    cyc(0, 0, 1, 0, 0);
    idle(2);

    // Timeout on the short-limit instance, then a second normal op.
    for (int k = 0; k < 8; k++) cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    idle(3);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 1, 0, 0);
    cyc(0, 1, 0, 0, 0);
    idle(3);

    // Both stall sources together, counter saturation, clear during a stall.
    for (int k = 0; k < 20; k++) cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    idle(70);

    // Reset in the middle of a WAIT.
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    pulse_reset(1'b1);
    idle(3);

    // Randomized traffic.
    req_h = 0;
    for (int n = 0; n < 1500; n++) begin
      if (!req_h) req_h = ($urandom_range(0, 3) == 0);
      else if ($urandom_range(0, 9) == 0) req_h = 0;
      if ($urandom_range(0, 299) == 0) begin
        pulse_reset(req_h);
      end else begin
        cyc($urandom_range(0, 3) == 0, req_h, $urandom_range(0, 5) == 0,
            $urandom_range(0, 24) == 0, $urandom_range(0, 40) == 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
